// File: rtl/mem_pkg.sv
// mem_pkg: op encodings, error codes and FSM states shared by the execute, memory
// and writeback stages.
package mem_pkg;
    localparam int unsigned MEM_WORDS   = 256;
    localparam int unsigned STACK_BASE  = 192;
    localparam int unsigned STACK_DEPTH = 64;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ERR_MISALIGN  = 2'd0,
        ERR_RANGE     = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_UNDERFLOW = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    // Codes 5-7 carry no meaning and are folded onto NONE.
    function automatic op_e decode_op(input logic [2:0] op);
        return (op > 3'd4) ? OP_NONE : op_e'(op);
    endfunction
endpackage

// File: rtl/mem_access_unit_stack_ptr.sv
// stack_ptr: word-index stack pointer with full/empty flags used by the overflow and
// underflow checks.
module stack_ptr #(
    parameter int unsigned BASE  = 192,
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        dec,
    output logic [31:0] sp,
    output logic        full,
    output logic        empty
);
    always_ff @(posedge clk) begin
        if (rst) sp <= 32'(BASE);
        else if (inc) sp <= sp + 32'd1;
        else if (dec) sp <= sp - 32'd1;
    end

    assign full  = sp == 32'(BASE + DEPTH);
    assign empty = sp == 32'(BASE);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage controller; checks and issues one request at a time,
// owns the stack pointer and returns load/pop/ALU results to writeback.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = mem_pkg::MEM_WORDS,
    parameter int unsigned STACK_BASE  = mem_pkg::STACK_BASE,
    parameter int unsigned STACK_DEPTH = mem_pkg::STACK_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_rd,
    input  logic        in_wb_en,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] sp
);
    state_e      state, nxt;
    op_e         r_op;
    logic [31:0] r_addr, r_data;
    logic [4:0]  r_rd;
    logic        r_wb_en, r_bad;
    err_e        r_code;
    op_e         op_n;
    logic        mem_op, mis, oor, ovf, unf, bad, accept;
    err_e        code;
    logic        full, empty, good, inc, dec, wb_none, in_wait;

    stack_ptr #(.BASE(STACK_BASE), .DEPTH(STACK_DEPTH)) u_sp (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc),
        .dec  (dec),
        .sp   (sp),
        .full (full),
        .empty(empty)
    );

    // Checks run against the live sp, which is stable while IDLE.
    always_comb begin
        op_n   = decode_op(in_op);
        mem_op = op_n == OP_LOAD || op_n == OP_STORE;
        mis    = mem_op && |in_addr[1:0];
        oor    = mem_op && {2'b00, in_addr[31:2]} >= 32'(MEM_WORDS);
        ovf    = op_n == OP_PUSH && full;
        unf    = op_n == OP_POP && empty;
        bad    = mis | oor | ovf | unf;
        code   = mis ? ERR_MISALIGN : oor ? ERR_RANGE : ovf ? ERR_OVERFLOW : ERR_UNDERFLOW;
        accept = state == S_IDLE && in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_NONE;
            r_addr  <= '0;
            r_data  <= '0;
            r_rd    <= '0;
            r_wb_en <= 1'b0;
            r_bad   <= 1'b0;
            r_code  <= ERR_MISALIGN;
        end else if (accept) begin
            r_op    <= op_n;
            r_addr  <= in_addr;
            r_data  <= in_data;
            r_rd    <= in_rd;
            r_wb_en <= in_wb_en;
            r_bad   <= bad;
            r_code  <= code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state == S_IDLE  ? (in_valid ? S_ISSUE : S_IDLE) :
              state == S_ISSUE ? ((!r_bad && (r_op == OP_LOAD || r_op == OP_POP)) ? S_WAIT : S_IDLE) :
                                 S_IDLE;
    end

    assign good = state == S_ISSUE && !r_bad;
    assign inc  = good && r_op == OP_PUSH;
    assign dec  = good && r_op == OP_POP;

    // Memory-side outputs are all zero outside a legal ISSUE; POP addresses the slot below sp.
    always_comb begin
        in_ready  = state == S_IDLE;
        mem_read  = good && (r_op == OP_LOAD || r_op == OP_POP);
        mem_write = good && (r_op == OP_STORE || r_op == OP_PUSH);
        mem_addr  = !good              ? 32'd0 :
                    r_op == OP_PUSH    ? sp << 2 :
                    r_op == OP_POP     ? (sp - 32'd1) << 2 :
                    (r_op == OP_LOAD || r_op == OP_STORE) ? r_addr : 32'd0;
        mem_wdata = mem_write ? r_data : 32'd0;
        wb_none   = good && r_op == OP_NONE;
        in_wait   = state == S_WAIT;
        wb_valid  = wb_none | in_wait;
        wb_we     = in_wait | (wb_none & r_wb_en);
        wb_rd     = wb_valid ? r_rd : 5'd0;
        wb_data   = in_wait ? mem_rdata : wb_none ? r_addr : 32'd0;
        err       = state == S_ISSUE && r_bad;
        err_code  = err ? r_code : ERR_MISALIGN;
    end
endmodule
